divider_seq_param: RTL and testbench

DIVIDER_SEQ_PARAM -- requirements
Module: divider_seq_param

---
 rtl/divider_seq_param.sv | 100 ++++++++++
 tb/tb_divider_seq_param.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq_param.sv
// Sequential restoring divider: unsigned N-bit dividend by M-bit divisor, one quotient bit per cycle.
// Start handshake: init is accepted only when busy is low; requests and operand changes while busy are dropped.
module divider_seq_param #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic [N-1:0] resultado,
    output logic [M-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_zero,
    output logic [1:0]   dbg_state
);

    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ITER   = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    logic [1:0]    state;
    logic [N-1:0]  dvd_q;
    logic [N-1:0]  quo_q;
    logic [M-1:0]  dvs_q;
    logic [M-1:0]  rem_q;
    logic [CW-1:0] cnt_q;
    logic          zero_q;

    logic [M:0]    shifted;
    logic [M-1:0]  diff;
    logic          fits;

    // rem_q < divisor always holds, so the shifted partial remainder fits in M+1 bits
    // and a successful subtraction always fits back into M bits.
    always_comb begin
        shifted = {rem_q, dvd_q[N-1]};
        fits    = (shifted >= {1'b0, dvs_q});
        diff    = shifted[M-1:0] - dvs_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dvd_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            zero_q    <= 1'b0;
            resultado <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (init) begin
                        dvd_q  <= dividend;
                        dvs_q  <= divisor;
                        rem_q  <= '0;
                        quo_q  <= '0;
                        cnt_q  <= CW'(N);
                        zero_q <= (divisor == '0);
                        state  <= (divisor == '0) ? FINISH : ITER;
                    end
                end
                ITER: begin
                    rem_q <= fits ? diff : shifted[M-1:0];
                    quo_q <= {quo_q[N-2:0], fits};
                    dvd_q <= {dvd_q[N-2:0], 1'b0};
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                    if (cnt_q == CW'(1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    // Results and done are registered on the way out of FINISH.
                    done      <= 1'b1;
                    resultado <= zero_q ? '1 : quo_q;
                    remainder <= zero_q ? '0 : rem_q;
                    div_zero  <= zero_q;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_divider_seq_param.sv
// Bench for divider_seq_param: three parameter sets run side by side against a
// timeline/arithmetic model, plus directed literal cases.
module tb_divider_seq_param;

    localparam int NN[3] = '{8, 16, 12};
    localparam int MM[3] = '{4, 8, 12};

    logic clk = 1'b0;
    logic rst;
    logic        init [3];
    logic [15:0] dvd  [3];
    logic [15:0] dvs  [3];

    logic [7:0]  res0;  logic [3:0]  rem0;  logic busy0, done0, dz0;  logic [1:0] st0;
    logic [15:0] res1;  logic [7:0]  rem1;  logic busy1, done1, dz1;  logic [1:0] st1;
    logic [11:0] res2;  logic [11:0] rem2;  logic busy2, done2, dz2;  logic [1:0] st2;

    logic [15:0] res_a [3];
    logic [15:0] rem_a [3];
    logic        busy_a [3];
    logic        done_a [3];
    logic        dz_a [3];

    int n_checks = 0;
    int n_fail   = 0;
    logic check_en = 1'b0;

    // model state
    int          m_cnt [3] = '{0, 0, 0};
    logic        m_done [3];
    logic [15:0] m_res [3];
    logic [15:0] m_rem [3];
    logic        m_dz [3];
    logic [15:0] m_fa [3];
    logic [15:0] m_fb [3];
    logic [15:0] p_a [3];
    logic [15:0] p_b [3];
    logic [15:0] p_q [3];
    logic [15:0] p_r [3];
    logic        p_z [3];

    always #5 clk = ~clk;

    divider_seq_param #(.N(8), .M(4)) u0 (
        .clk(clk), .rst(rst), .init(init[0]), .dividend(dvd[0][7:0]), .divisor(dvs[0][3:0]),
        .resultado(res0), .remainder(rem0), .busy(busy0), .done(done0), .div_zero(dz0),
        .dbg_state(st0)
    );
    divider_seq_param #(.N(16), .M(8)) u1 (
        .clk(clk), .rst(rst), .init(init[1]), .dividend(dvd[1]), .divisor(dvs[1][7:0]),
        .resultado(res1), .remainder(rem1), .busy(busy1), .done(done1), .div_zero(dz1),
        .dbg_state(st1)
    );
    divider_seq_param #(.N(12), .M(12)) u2 (
        .clk(clk), .rst(rst), .init(init[2]), .dividend(dvd[2][11:0]), .divisor(dvs[2][11:0]),
        .resultado(res2), .remainder(rem2), .busy(busy2), .done(done2), .div_zero(dz2),
        .dbg_state(st2)
    );

    always_comb begin
        res_a[0] = 16'(res0); rem_a[0] = 16'(rem0); busy_a[0] = busy0; done_a[0] = done0; dz_a[0] = dz0;
        res_a[1] = res1;      rem_a[1] = 16'(rem1); busy_a[1] = busy1; done_a[1] = done1; dz_a[1] = dz1;
        res_a[2] = 16'(res2); rem_a[2] = 16'(rem2); busy_a[2] = busy2; done_a[2] = done2; dz_a[2] = dz2;
    end

    function automatic logic [15:0] mask(input int w);
        return 16'((32'd1 << w) - 1);
    endfunction

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 25)
                $display("FAIL u%0d %s: actual %0d required %0d (t=%0t)", inst, nm, act, exp, $time);
        end
    endtask

    // Reference model: a busy countdown per instance and plain / and % for the results.
    initial begin : model
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rst) begin
                    m_cnt[i] = 0; m_done[i] = 1'b0; m_res[i] = '0; m_rem[i] = '0; m_dz[i] = 1'b0;
                end else begin
                    m_done[i] = 1'b0;
                    if (m_cnt[i] > 0) begin
                        m_cnt[i]--;
                        if (m_cnt[i] == 0) begin
                            m_done[i] = 1'b1;
                            m_res[i]  = p_q[i];
                            m_rem[i]  = p_r[i];
                            m_dz[i]   = p_z[i];
                            m_fa[i]   = p_a[i];
                            m_fb[i]   = p_b[i];
                        end
                    end else if (init[i]) begin
                        p_a[i] = dvd[i] & mask(NN[i]);
                        p_b[i] = dvs[i] & mask(MM[i]);
                        if (p_b[i] == '0) begin
                            p_q[i] = mask(NN[i]); p_r[i] = '0; p_z[i] = 1'b1; m_cnt[i] = 1;
                        end else begin
                            p_q[i] = p_a[i] / p_b[i]; p_r[i] = p_a[i] % p_b[i]; p_z[i] = 1'b0;
                            m_cnt[i] = NN[i] + 1;
                        end
                    end
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (check_en) begin
                for (int i = 0; i < 3; i++) begin
                    chk("busy", i, 32'(busy_a[i]), 32'(m_cnt[i] > 0));
                    chk("done", i, 32'(done_a[i]), 32'(m_done[i]));
                    chk("resultado", i, 32'(res_a[i]), 32'(m_res[i]));
                    chk("remainder", i, 32'(rem_a[i]), 32'(m_rem[i]));
                    chk("div_zero", i, 32'(dz_a[i]), 32'(m_dz[i]));
                    if (m_done[i] && !m_dz[i]) begin
                        chk("identity", i, 32'(res_a[i]) * 32'(m_fb[i]) + 32'(rem_a[i]), 32'(m_fa[i]));
                        chk("rem_lt_div", i, 32'(rem_a[i] < m_fb[i]), 32'd1);
                    end
                end
            end
        end
    end

    // Called at #1 after the accepting edge; counts edges until done and busy cycles seen.
    task automatic wait_done(input int i, output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy_a[i] ? 1 : 0;
        while (lat < 100 && !done_a[i]) begin
            @(posedge clk); #1;
            lat++;
            if (!done_a[i] && busy_a[i]) bcnt++;
        end
        if (!done_a[i]) chk("done_timeout", i, 32'd0, 32'd1);
    endtask

    task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input logic ez,
                          input int elat, input string tag);
        int lat, bc;
        @(posedge clk); #1;
        init[i] = 1'b1; dvd[i] = a; dvs[i] = b;
        @(posedge clk); #1;
        init[i] = 1'b0;
        wait_done(i, lat, bc);
        chk({tag, "_latency"}, i, 32'(lat), 32'(elat));
        chk({tag, "_busy_cycles"}, i, 32'(bc), 32'(elat));
        chk({tag, "_q"}, i, 32'(res_a[i]), 32'(eq));
        chk({tag, "_r"}, i, 32'(rem_a[i]), 32'(er));
        chk({tag, "_dz"}, i, 32'(dz_a[i]), 32'(ez));
    endtask

    initial begin : driver
        int lat, bc, t, last, pulses, dcount;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            init[i] = 1'b0; dvd[i] = '0; dvs[i] = '0;
        end
        @(posedge clk); #1;
        check_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("reset_busy", i, 32'(busy_a[i]), 32'd0);
            chk("reset_done", i, 32'(done_a[i]), 32'd0);
            chk("reset_q", i, 32'(res_a[i]), 32'd0);
        end

        run_op(0, 16'd200, 16'd7, 16'd28, 16'd4, 1'b0, 9, "200div7");
        run_op(0, 16'd255, 16'd1, 16'd255, 16'd0, 1'b0, 9, "255div1");
        run_op(0, 16'd3, 16'd9, 16'd0, 16'd3, 1'b0, 9, "3div9");
        run_op(0, 16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 9, "0div5");
        run_op(0, 16'd15, 16'd0, 16'd255, 16'd0, 1'b1, 1, "15div0");
        run_op(0, 16'd15, 16'd3, 16'd5, 16'd0, 1'b0, 9, "15div3");
        run_op(1, 16'd50000, 16'd255, 16'd196, 16'd20, 1'b0, 17, "50000div255");
        run_op(2, 16'd4095, 16'd4095, 16'd1, 16'd0, 1'b0, 13, "4095div4095");
        run_op(2, 16'd100, 16'd4000, 16'd0, 16'd100, 1'b0, 13, "100div4000");

        // Ignored start while busy, operands changed mid-run.
        @(posedge clk); #1;
        init[0] = 1'b1; dvd[0] = 16'd100; dvs[0] = 16'd3;
        @(posedge clk); #1;
        init[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 init[0] = 1'b1; dvd[0] = 16'd77; dvs[0] = 16'd5;
        @(posedge clk); #1;
        init[0] = 1'b0;
        wait_done(0, lat, bc);
        chk("ignored_init_q", 0, 32'(res_a[0]), 32'd33);
        chk("ignored_init_r", 0, 32'(rem_a[0]), 32'd1);
        @(posedge clk); #1;
        chk("no_queued_start", 0, 32'(busy_a[0]), 32'd0);

        // Abort with reset mid-run.
        @(posedge clk); #1;
        init[0] = 1'b1; dvd[0] = 16'd200; dvs[0] = 16'd7;
        @(posedge clk); #1;
        init[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_q", 0, 32'(res_a[0]), 32'd0);
        chk("abort_r", 0, 32'(rem_a[0]), 32'd0);
        chk("abort_busy", 0, 32'(busy_a[0]), 32'd0);
        chk("abort_dz", 0, 32'(dz_a[0]), 32'd0);
        dcount = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done_a[0]) dcount++;
        end
        chk("abort_no_done", 0, 32'(dcount), 32'd0);

        // init held high: back-to-back runs.
        @(posedge clk); #1;
        init[1] = 1'b1; dvd[1] = 16'd50000; dvs[1] = 16'd255;
        t = 0; last = -1; pulses = 0;
        while (pulses < 3 && t < 200) begin
            @(posedge clk); #1;
            t++;
            if (done_a[1]) begin
                if (last >= 0) chk("b2b_period", 1, 32'(t - last), 32'd18);
                else           chk("b2b_first", 1, 32'(t), 32'd18);
                chk("b2b_q", 1, 32'(res_a[1]), 32'd196);
                chk("b2b_r", 1, 32'(rem_a[1]), 32'd20);
                last = t;
                pulses++;
            end
        end
        chk("b2b_pulses", 1, 32'(pulses), 32'd3);
        init[1] = 1'b0;
        repeat (20) @(posedge clk);

        // Randomized phase on all three parameter sets at once.
        for (int c = 0; c < 45000; c++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 2999) == 0);
            for (int i = 0; i < 3; i++) begin
                init[i] = ($urandom_range(0, 9) != 0);
                dvd[i]  = 16'($urandom) & mask(NN[i]);
                if ($urandom_range(0, 3) == 0) dvd[i] = dvd[i] >> $urandom_range(0, NN[i] - 1);
                dvs[i]  = ($urandom_range(0, 15) == 0) ? 16'd0 : (16'($urandom) & mask(MM[i]));
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) init[i] = 1'b0;
        repeat (25) @(posedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
